// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared definitions for the PLL lock controller.
//   - pll_state_e : FSM state encoding (also driven out on the state port)
//   - Def*        : default values for the controller parameters
//   - cnt_width() : width needed for a counter that must hold 0..max_val
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPllRst  = 3'd1,
        StAcquire = 3'd2,
        StLocked  = 3'd3,
        StFault   = 3'd4
    } pll_state_e;

    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefLockTol    = 4;
    localparam int unsigned DefUnlockTol  = 16;
    localparam int unsigned DefLockCnt    = 8;
    localparam int unsigned DefUnlockCnt  = 4;
    localparam int unsigned DefAcqTimeout = 256;
    localparam int unsigned DefRefTimeout = 4096;
    localparam int unsigned DefRstCycles  = 16;
    localparam int unsigned DefMaxRetry   = 3;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_phase_meter.sv
// pll_phase_meter: measures the clk-cycle distance from a ref_edge to the
// following fb_edge.
//   clk, rst   : system clock, async active-high reset
//   active     : measurement enabled; low discards any running measurement
//   ref_edge   : starts a measurement (a second one before fb is a slip)
//   fb_edge    : ends the running measurement
//   phase_err  : last measured distance (all-ones on slip), registered
//   err_valid  : one-cycle pulse when phase_err updates
module pll_phase_meter
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             ref_edge,
    input  logic             fb_edge,
    output logic [CNT_W-1:0] phase_err,
    output logic             err_valid
);

    logic             running_q, running_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment; latching cnt_inc on fb makes the result equal
    // the number of clk edges between ref and fb (coincident edges give 0).
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        if (!active) begin
            running_d = 1'b0;
            cnt_d     = '0;
        end else if (ref_edge && fb_edge) begin
            // Coincident edges: zero error, any older open measurement is dropped.
            err_d     = '0;
            valid_d   = 1'b1;
            running_d = 1'b0;
            cnt_d     = '0;
        end else if (ref_edge) begin
            if (running_q) begin
                err_d   = {CNT_W{1'b1}};
                valid_d = 1'b1;
            end
            running_d = 1'b1;
            cnt_d     = '0;
        end else if (running_q) begin
            if (fb_edge) begin
                err_d     = cnt_inc;
                valid_d   = 1'b1;
                running_d = 1'b0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
        end
    end

    assign phase_err = err_q;
    assign err_valid = valid_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset / acquisition / lock-monitor controller.
//   clk, rst   : system clock, async active-high reset
//   enable     : link alive; low returns to IDLE
//   ref_edge   : one-cycle pulse per link rising edge
//   fb_edge    : one-cycle pulse per PLL vco rising edge
//   pll_nrst   : PLL reset (active low)
//   locked     : lock status
//   lock_lost  : one-cycle pulse when lock is dropped
//   fault      : acquisition abandoned after MAX_RETRY failures
//   state      : current FSM state (pll_state_e encoding)
//   phase_err  : last measured ref->fb distance in clk cycles
//   err_valid  : one-cycle pulse when phase_err updates
//   retry_cnt  : failed acquisitions since last lock / IDLE
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned LOCK_TOL    = DefLockTol,
    parameter int unsigned UNLOCK_TOL  = DefUnlockTol,
    parameter int unsigned LOCK_CNT    = DefLockCnt,
    parameter int unsigned UNLOCK_CNT  = DefUnlockCnt,
    parameter int unsigned ACQ_TIMEOUT = DefAcqTimeout,
    parameter int unsigned REF_TIMEOUT = DefRefTimeout,
    parameter int unsigned RST_CYCLES  = DefRstCycles,
    parameter int unsigned MAX_RETRY   = DefMaxRetry
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ref_edge,
    input  logic             fb_edge,
    output logic             pll_nrst,
    output logic             locked,
    output logic             lock_lost,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] phase_err,
    output logic             err_valid,
    output logic [1:0]       retry_cnt
);

    localparam int unsigned RstW  = cnt_width(RST_CYCLES);
    localparam int unsigned GoodW = cnt_width(LOCK_CNT);
    localparam int unsigned BadW  = cnt_width(UNLOCK_CNT);
    localparam int unsigned AcqW  = cnt_width(ACQ_TIMEOUT);
    localparam int unsigned TmoW  = cnt_width(REF_TIMEOUT);

    localparam logic [RstW-1:0]  RstLast    = RstW'(RST_CYCLES - 1);
    localparam logic [GoodW-1:0] GoodLast   = GoodW'(LOCK_CNT - 1);
    localparam logic [BadW-1:0]  BadLast    = BadW'(UNLOCK_CNT - 1);
    localparam logic [AcqW-1:0]  AcqLast    = AcqW'(ACQ_TIMEOUT - 1);
    localparam logic [TmoW-1:0]  TmoLast    = TmoW'(REF_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LockTolC   = CNT_W'(LOCK_TOL);
    localparam logic [CNT_W-1:0] UnlockTolC = CNT_W'(UNLOCK_TOL);
    localparam logic [1:0]       MaxRetryC  = 2'(MAX_RETRY);

    pll_state_e       state_q, state_d;
    logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [BadW-1:0]  bad_q, bad_d;
    logic [AcqW-1:0]  acq_q, acq_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [1:0]       retry_q, retry_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic             fault_q, fault_d;
    logic             nrst_q, nrst_d;

    logic             meas_active;
    logic [CNT_W-1:0] meas_err;
    logic             meas_valid;
    logic             good_meas, bad_meas, ref_tmo_hit, do_retry;
    logic [TmoW-1:0]  tmo_next;
    logic [1:0]       retry_inc;

    assign meas_active = (state_q == StAcquire) || (state_q == StLocked);

    pll_phase_meter #(
        .CNT_W (CNT_W)
    ) u_meter (
        .clk       (clk),
        .rst       (rst),
        .active    (meas_active),
        .ref_edge  (ref_edge),
        .fb_edge   (fb_edge),
        .phase_err (meas_err),
        .err_valid (meas_valid)
    );

    assign good_meas   = meas_valid && (meas_err <= LockTolC);
    assign bad_meas    = meas_valid && (meas_err > UnlockTolC);
    assign ref_tmo_hit = !ref_edge && (tmo_q == TmoLast);
    assign tmo_next    = ref_edge ? '0 : tmo_q + 1'b1;
    assign retry_inc   = retry_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        good_d    = good_q;
        bad_d     = bad_q;
        acq_d     = acq_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        locked_d  = locked_q;
        lost_d    = 1'b0;
        fault_d   = fault_q;
        nrst_d    = nrst_q;
        do_retry  = 1'b0;

        if (!enable) begin
            // Disable overrides every other event in this cycle.
            state_d   = StIdle;
            rst_cnt_d = '0;
            good_d    = '0;
            bad_d     = '0;
            acq_d     = '0;
            tmo_d     = '0;
            retry_d   = '0;
            locked_d  = 1'b0;
            fault_d   = 1'b0;
            nrst_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StPllRst;
                    rst_cnt_d = '0;
                end
                StPllRst: begin
                    if (rst_cnt_q == RstLast) begin
                        state_d = StAcquire;
                        nrst_d  = 1'b1;
                        good_d  = '0;
                        acq_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                StAcquire: begin
                    tmo_d = tmo_next;
                    if (ref_edge) acq_d = acq_q + 1'b1;
                    if (meas_valid) good_d = good_meas ? good_q + 1'b1 : '0;
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (good_meas && (good_q == GoodLast)) begin
                        state_d  = StLocked;
                        locked_d = 1'b1;
                        retry_d  = '0;
                        bad_d    = '0;
                    end else if ((ref_edge && (acq_q == AcqLast)) || ref_tmo_hit) begin
                        do_retry = 1'b1;
                    end
                end
                StLocked: begin
                    tmo_d = tmo_next;
                    if (meas_valid) bad_d = bad_meas ? bad_q + 1'b1 : '0;
                    if (ref_tmo_hit) begin
                        do_retry = 1'b1;
                        lost_d   = 1'b1;
                    end else if (bad_meas && (bad_q == BadLast)) begin
                        state_d  = StAcquire;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                        good_d   = '0;
                        acq_d    = '0;
                    end
                end
                StFault: begin
                    fault_d = 1'b1;
                    nrst_d  = 1'b0;
                end
                default: state_d = StIdle;
            endcase

            if (do_retry) begin
                retry_d   = retry_inc;
                locked_d  = 1'b0;
                nrst_d    = 1'b0;
                rst_cnt_d = '0;
                good_d    = '0;
                bad_d     = '0;
                acq_d     = '0;
                tmo_d     = '0;
                if (retry_inc == MaxRetryC) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end else begin
                    state_d = StPllRst;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rst_cnt_q <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            acq_q     <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
            fault_q   <= 1'b0;
            nrst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            acq_q     <= acq_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            locked_q  <= locked_d;
            lost_q    <= lost_d;
            fault_q   <= fault_d;
            nrst_q    <= nrst_d;
        end
    end

    assign state     = state_q;
    assign pll_nrst  = nrst_q;
    assign locked    = locked_q;
    assign lock_lost = lost_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign phase_err = meas_err;
    assign err_valid = meas_valid;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed self-checking bench for pll_lock_ctrl with
// default parameters. Inputs change and outputs are sampled 1 time unit
// after each rising clk edge.
module tb_pll_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        ref_edge = 1'b0;
    logic        fb_edge = 1'b0;
    logic        pll_nrst, locked, lock_lost, fault, err_valid;
    logic [2:0]  state;
    logic [15:0] phase_err;
    logic [1:0]  retry_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int ev_cnt = 0;
    int lost_cnt = 0;
    int last_ref_cyc = 0;

    pll_lock_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ref_edge  (ref_edge),
        .fb_edge   (fb_edge),
        .pll_nrst  (pll_nrst),
        .locked    (locked),
        .lock_lost (lock_lost),
        .fault     (fault),
        .state     (state),
        .phase_err (phase_err),
        .err_valid (err_valid),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        ev_cnt   += int'(err_valid);
        lost_cnt += int'(lock_lost);
    endtask

    // One ref period: ref on slot 0, fb on slot fb_dly (negative = no fb).
    task automatic ref_period(input int fb_dly, input int period);
        for (int i = 0; i < period; i++) begin
            ref_edge = (i == 0);
            fb_edge  = (i == fb_dly);
            tick();
            if (i == 0) last_ref_cyc = cycle;
        end
        ref_edge = 1'b0;
        fb_edge  = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] tgt, input int budget);
        int n = 0;
        while (state !== tgt && n < budget) begin
            tick();
            n++;
        end
        check(tag, state, tgt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int waited;

        // Async reset before any clock edge.
        #2 rst = 1'b1;
        #2;
        check("rst_state", state, 0);
        check("rst_nrst", pll_nrst, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lock_lost, 0);
        check("rst_fault", fault, 0);
        check("rst_valid", err_valid, 0);
        check("rst_err", phase_err, 0);
        check("rst_retry", retry_cnt, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("idle_hold", state, 0);

        // Nominal lock.
        enable = 1'b1;
        tick();
        check("pllrst_entry", state, 1);
        check("pllrst_nrst", pll_nrst, 0);
        repeat (15) tick();
        check("pllrst_last", state, 1);
        check("pllrst_last_nrst", pll_nrst, 0);
        tick();
        check("acq_entry", state, 2);
        check("acq_nrst", pll_nrst, 1);
        repeat (7) ref_period(2, 10);
        check("acq7_locked", locked, 0);
        check("acq7_state", state, 2);
        ref_period(2, 10);
        check("lock_locked", locked, 1);
        check("lock_state", state, 3);
        check("lock_retry", retry_cnt, 0);
        check("lock_err", phase_err, 2);
        check("lock_evcnt", ev_cnt, 8);
        check("lock_nrst", pll_nrst, 1);

        // Coincident edges.
        ref_edge = 1'b1;
        fb_edge  = 1'b1;
        tick();
        last_ref_cyc = cycle;
        ref_edge = 1'b0;
        fb_edge  = 1'b0;
        check("coin_valid", err_valid, 1);
        check("coin_err", phase_err, 0);
        tick();
        check("coin_pulse_end", err_valid, 0);
        repeat (8) tick();

        // Loss of lock: 3 bad / 1 good / 3 bad must not unlock.
        snap = lost_cnt;
        repeat (3) ref_period(20, 30);
        check("bad3_err", phase_err, 20);
        ref_period(2, 30);
        repeat (3) ref_period(20, 30);
        check("bad313_state", state, 3);
        check("bad313_locked", locked, 1);
        check("bad313_nolost", lost_cnt - snap, 0);
        ref_period(2, 30);
        repeat (3) ref_period(20, 30);
        check("bad3_still_locked", state, 3);
        ref_period(20, 30);
        check("unlock_lost_once", lost_cnt - snap, 1);
        check("unlock_locked", locked, 0);
        check("unlock_state", state, 2);

        // Relock, then ref loss.
        repeat (8) ref_period(2, 10);
        check("relock", locked, 1);
        snap = lost_cnt;
        waited = 0;
        while (state == 3'd3 && waited < 5000) begin
            tick();
            waited++;
        end
        check("refloss_gap", cycle - last_ref_cyc, 4096);
        check("refloss_state", state, 1);
        check("refloss_retry", retry_cnt, 1);
        check("refloss_lost", lost_cnt - snap, 1);
        check("refloss_locked", locked, 0);
        check("refloss_nrst", pll_nrst, 0);

        // Retry to fault: fb never arrives.
        enable = 1'b0;
        tick();
        check("dis_state", state, 0);
        check("dis_retry", retry_cnt, 0);
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_state("retry_wait_acq", 3'd2, 100);
            repeat (255) ref_period(-1, 4);
            check("retry_pre_state", state, 2);
            check("retry_pre_cnt", retry_cnt, k - 1);
            ref_period(-1, 4);
            check("retry_cnt", retry_cnt, k);
            check("retry_state", state, (k == 3) ? 4 : 1);
        end
        check("slip_err", phase_err, 16'hFFFF);
        repeat (5) tick();
        check("fault_hold", fault, 1);
        check("fault_nrst", pll_nrst, 0);
        check("fault_state", state, 4);
        enable = 1'b0;
        tick();
        check("fault_dis_state", state, 0);
        check("fault_dis_fault", fault, 0);

        // Async reset mid-measurement in LOCKED.
        enable = 1'b1;
        wait_state("ar_wait_acq", 3'd2, 100);
        repeat (8) ref_period(2, 10);
        check("ar_locked", state, 3);
        ref_edge = 1'b1;
        tick();
        ref_edge = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("ar_state", state, 0);
        check("ar_nrst", pll_nrst, 0);
        check("ar_locked0", locked, 0);
        check("ar_lost", lock_lost, 0);
        check("ar_fault", fault, 0);
        check("ar_valid", err_valid, 0);
        check("ar_err", phase_err, 0);
        check("ar_retry", retry_cnt, 0);
        snap = ev_cnt;
        fb_edge = 1'b1;
        tick();
        fb_edge = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("ar_first_state", state, 1);
        fb_edge = 1'b1;
        tick();
        fb_edge = 1'b0;
        repeat (8) tick();
        check("ar_no_stale_valid", ev_cnt - snap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CNT_W, 16, phase-error / timeout counter width.
- LOCK_TOL, 4, max error in clk cycles counted as "good".
- UNLOCK_TOL, 16, error above this is counted as "bad" while locked.
- LOCK_CNT, 8, consecutive good measurements needed to declare lock.
- UNLOCK_CNT, 4, consecutive bad measurements needed to declare loss of lock.
- ACQ_TIMEOUT, 256, ref edges allowed in ACQUIRE before a retry.
- REF_TIMEOUT, 4096, clk cycles without ref_edge before a retry.
- RST_CYCLES, 16, clk cycles the PLL is held in reset.
- MAX_RETRY, 3, failed acquisitions before FAULT.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock.
- rst, in, 1, asynchronous, active-high reset.
- enable, in, 1, link alive; low forces IDLE.
- ref_edge, in, 1, one-cycle pulse on a link rising edge.
- fb_edge, in, 1, one-cycle pulse on a PLL vco rising edge.
- pll_nrst, out, 1, drives the PLL nrst input.
- locked, out, 1, PLL locked status.
- lock_lost, out, 1, one-cycle pulse on loss of lock.
- fault, out, 1, acquisition abandoned.
- state, out, 3, current FSM state.
- phase_err, out, CNT_W, last measured error.
- err_valid, out, 1, one-cycle pulse when phase_err updates.
- retry_cnt, out, 2, failed acquisitions so far.

Function
REQ-003 The FSM states SHALL be IDLE=0, PLL_RST=1, ACQUIRE=2, LOCKED=3 and FAULT=4. All outputs SHALL be registered.
REQ-004 enable=0 in any state SHALL move the FSM to IDLE on the next clk. IDLE SHALL clear pll_nrst, locked, the good/bad/acquisition counters and retry_cnt.
REQ-005 In IDLE with enable=1, the FSM SHALL move to PLL_RST on the next clk.
REQ-006 PLL_RST SHALL hold pll_nrst=0 for exactly RST_CYCLES clk cycles, then enter ACQUIRE. pll_nrst SHALL be 1 in every ACQUIRE and LOCKED cycle.
REQ-007 Phase measurement, active in ACQUIRE and LOCKED:
- A ref_edge SHALL start an error counter at 0.
- The counter SHALL increment once per clk and saturate at 2^CNT_W-1.
- The first subsequent fb_edge SHALL latch the counter into phase_err and pulse err_valid.
REQ-008 ref_edge and fb_edge in the same cycle SHALL yield phase_err=0 and err_valid the next cycle.
REQ-009 A second ref_edge before any fb_edge SHALL count as a slip: phase_err=all-ones, err_valid pulses, and a new measurement starts.
REQ-010 In ACQUIRE, each err_valid with phase_err<=LOCK_TOL SHALL increment good_cnt; any other err_valid SHALL clear good_cnt.
REQ-011 When good_cnt reaches LOCK_CNT, the FSM SHALL enter LOCKED. locked=1 and retry_cnt=0 SHALL take effect in the same clk that state shows 3.
REQ-012 Each ref_edge in ACQUIRE SHALL increment acq_cnt. When acq_cnt reaches ACQ_TIMEOUT:
- retry_cnt SHALL increment.
- If the new retry_cnt equals MAX_RETRY, the FSM SHALL enter FAULT; otherwise it SHALL enter PLL_RST.
REQ-013 In LOCKED, each err_valid with phase_err>UNLOCK_TOL SHALL increment bad_cnt; any other err_valid SHALL clear bad_cnt.
REQ-014 When bad_cnt reaches UNLOCK_CNT, the FSM SHALL enter ACQUIRE, clear locked and pulse lock_lost for exactly one cycle. good_cnt and acq_cnt SHALL restart at 0.
REQ-015 REF_TIMEOUT consecutive clk cycles without ref_edge in ACQUIRE or LOCKED SHALL be handled exactly as an ACQUIRE timeout (REQ-012). If the FSM was in LOCKED, lock_lost SHALL also pulse.
REQ-016 FAULT SHALL hold fault=1 and pll_nrst=0 until enable=0 or rst.
REQ-017 When lock-count and timeout conditions occur in the same cycle, the lock transition SHALL win.
REQ-018 When a disable and any other event occur in the same cycle, the disable SHALL win.

Reset
REQ-019 rst=1 SHALL asynchronously force the following, independent of clk:
- state=IDLE;
- pll_nrst=0, locked=0, lock_lost=0, fault=0, err_valid=0;
- phase_err=0, retry_cnt=0, all internal counters 0.
REQ-020 Reset release SHALL be synchronous to clk. The first transition after release SHALL follow REQ-005.
REQ-021 A reset asserted mid-measurement SHALL discard the partial measurement; no err_valid SHALL follow.

Structure
REQ-022 The state encoding and the parameter defaults SHALL reside in the shared package pll_ctrl_pkg.
REQ-023 The phase measurement (REQ-007 to REQ-009) SHALL be a sub-module named pll_phase_meter. It SHALL have clk, rst, an active input, ref_edge, fb_edge, phase_err and err_valid.

Verification
REQ-024 The bench SHALL cover these directed scenarios, with default parameters:
- Nominal lock: enable=1, then 8 ref periods with fb 2 clks after ref -> pll_nrst rises 16 clks after PLL_RST entry; locked=1 after the 8th err_valid; retry_cnt=0.
- Coincident edges: ref_edge and fb_edge in the same cycle -> phase_err=0 and err_valid one clk later.
- Loss of lock: from LOCKED, 4 measurements with error 20 -> lock_lost pulses once, locked=0, state=2. A 3-bad then 1-good then 3-bad pattern -> no unlock.
- Retry to fault: fb_edge never asserted for 3x256 ref edges -> retry_cnt goes 1, 2, then FAULT with fault=1 and pll_nrst=0. A following enable=0 -> IDLE.
- Ref loss: in LOCKED, ref_edge stopped for 4096 clks -> lock_lost pulses, state=PLL_RST, retry_cnt=1.
- Async reset: rst pulsed mid-measurement in LOCKED -> all outputs reach their reset values without a clk edge, and no stale err_valid appears.
